// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcodes, instruction fields and ID/EX bundle.
package alu_pkg;

   localparam logic [2:0] CTL_LD  = 3'b000;
   localparam logic [2:0] CTL_ADD = 3'b001;
   localparam logic [2:0] CTL_AND = 3'b010;
   localparam logic [2:0] CTL_SUB = 3'b011;
   localparam logic [2:0] CTL_ASL = 3'b100;
   localparam logic [2:0] CTL_OR  = 3'b101;
   localparam logic [2:0] CTL_ASR = 3'b110;
   localparam logic [2:0] CTL_NOP = 3'b111;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ASLA = 4'h5;
   localparam logic [3:0] OP_ASRA = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_BR   = 4'h9;
   localparam logic [3:0] OP_ADDI = 4'hA;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS_MSB  = 8;
   localparam int RS_LSB  = 6;
   localparam int RT_MSB  = 5;
   localparam int RT_LSB  = 3;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 6;

   typedef struct packed {
      logic       valid;
      logic [2:0] ctl;
      logic [2:0] rd;
      logic       wr_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       branch;
   } id_ex_t;

   localparam id_ex_t EX_BUBBLE = '{
      valid:  1'b0,
      ctl:    CTL_NOP,
      rd:     3'd0,
      wr_en:  1'b0,
      mem_rd: 1'b0,
      mem_wr: 1'b0,
      branch: 1'b0
   };

endpackage

// File: rtl/alu_ctl_decode.sv
// Opcode to ALU control and pipeline flag decoder.
module alu_ctl_decode (
   input  logic [3:0] op,
   output logic [2:0] ctl,
   output logic       wr_en,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       branch,
   output logic       uses_rs,
   output logic       uses_rt,
   output logic       imm_sel,
   output logic       illegal
);
   import alu_pkg::*;

   always_comb begin
      ctl     = CTL_NOP;
      wr_en   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      branch  = 1'b0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      imm_sel = 1'b0;
      illegal = 1'b0;
      unique case (op)
         OP_NOP: ;
         OP_ADD: begin
            ctl = CTL_ADD; wr_en = 1'b1;
            uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_SUB: begin
            ctl = CTL_SUB; wr_en = 1'b1;
            uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_AND: begin
            ctl = CTL_AND; wr_en = 1'b1;
            uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_OR: begin
            ctl = CTL_OR; wr_en = 1'b1;
            uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_ASLA: begin
            ctl = CTL_ASL; wr_en = 1'b1; uses_rs = 1'b1;
         end
         OP_ASRA: begin
            ctl = CTL_ASR; wr_en = 1'b1; uses_rs = 1'b1;
         end
         OP_LD: begin
            ctl = CTL_LD; wr_en = 1'b1;
            mem_rd = 1'b1; uses_rs = 1'b1;
         end
         OP_ST: begin
            ctl = CTL_LD; mem_wr = 1'b1;
            uses_rs = 1'b1; uses_rt = 1'b1;
         end
         OP_BR: begin
            ctl = CTL_NOP; branch = 1'b1;
         end
         OP_ADDI: begin
            ctl = CTL_ADD; wr_en = 1'b1;
            uses_rs = 1'b1; imm_sel = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage and ID/EX register feeding the ALU, with load-use
// hazard bubbling, downstream stall/flush and a bubble counter.
module alu_decode_stage #(
   parameter int SIZE  = 10,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [15:0]     instr,
   output logic            instr_ready,
   output logic [2:0]      rs_addr,
   output logic [2:0]      rt_addr,
   input  logic [SIZE-1:0] rs_data,
   input  logic [SIZE-1:0] rt_data,
   input  logic            stall_i,
   input  logic            flush_i,
   output logic            ex_valid,
   output logic [2:0]      ex_ctl,
   output logic [SIZE-1:0] ex_in1,
   output logic [SIZE-1:0] ex_in2,
   output logic [2:0]      ex_rd,
   output logic            ex_wr_en,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_branch,
   output logic            illegal_o,
   output logic [CNT_W-1:0] hazard_cnt
);
   import alu_pkg::*;

   logic [3:0]       op;
   logic [2:0]       rd_f;
   logic [IMM_W-1:0] imm;
   logic [SIZE-1:0]  imm_ext;

   logic [2:0] d_ctl;
   logic d_wr_en, d_mem_rd, d_mem_wr, d_branch;
   logic d_uses_rs, d_uses_rt, d_imm_sel, d_illegal, d_live;

   id_ex_t          ex_q, ex_d;
   logic [SIZE-1:0] in1_q, in1_d, in2_q, in2_d;
   logic            ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic hazard;
   logic sel_flush, sel_hold, sel_haz, sel_dec, sel_idle;

   assign op      = instr[OP_MSB:OP_LSB];
   assign rd_f    = instr[RD_MSB:RD_LSB];
   assign rs_addr = instr[RS_MSB:RS_LSB];
   assign rt_addr = instr[RT_MSB:RT_LSB];
   assign imm     = instr[IMM_MSB:IMM_LSB];
   assign imm_ext = {{(SIZE-IMM_W){imm[IMM_W-1]}}, imm};

   alu_ctl_decode u_dec (
      .op      (op),
      .ctl     (d_ctl),
      .wr_en   (d_wr_en),
      .mem_rd  (d_mem_rd),
      .mem_wr  (d_mem_wr),
      .branch  (d_branch),
      .uses_rs (d_uses_rs),
      .uses_rt (d_uses_rt),
      .imm_sel (d_imm_sel),
      .illegal (d_illegal)
   );

   assign d_live = (op != OP_NOP) && !d_illegal;

   assign hazard = ex_q.valid & ex_q.mem_rd & instr_valid &
                   (((ex_q.rd == rs_addr) & d_uses_rs) |
                    ((ex_q.rd == rt_addr) & d_uses_rt));

   // One-hot cycle selection; flush outranks stall outranks hazard.
   assign sel_flush = flush_i;
   assign sel_hold  = !flush_i & stall_i;
   assign sel_haz   = !flush_i & !stall_i & hazard;
   assign sel_dec   = !flush_i & !stall_i & !hazard & instr_valid;
   assign sel_idle  = !flush_i & !stall_i & !hazard & !instr_valid;

   assign instr_ready = !rst & !sel_hold & !sel_haz;

   always_comb begin
      ex_d  = EX_BUBBLE;
      in1_d = '0;
      in2_d = '0;
      ill_d = 1'b0;
      cnt_d = cnt_q;
      unique case (1'b1)
         sel_hold: begin
            ex_d  = ex_q;
            in1_d = in1_q;
            in2_d = in2_q;
         end
         sel_haz: begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
         end
         sel_dec: begin
            ill_d = d_illegal;
            if (d_live) begin
               ex_d = '{
                  valid:  1'b1,
                  ctl:    d_ctl,
                  rd:     rd_f,
                  wr_en:  d_wr_en,
                  mem_rd: d_mem_rd,
                  mem_wr: d_mem_wr,
                  branch: d_branch
               };
               in1_d = d_uses_rs ? rs_data : '0;
               in2_d = d_imm_sel ? imm_ext :
                       d_uses_rt ? rt_data : '0;
            end
         end
         sel_flush, sel_idle: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= EX_BUBBLE;
         in1_q <= '0;
         in2_q <= '0;
         ill_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         in1_q <= in1_d;
         in2_q <= in2_d;
         ill_q <= ill_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_ctl     = ex_q.ctl;
   assign ex_rd      = ex_q.rd;
   assign ex_wr_en   = ex_q.wr_en;
   assign ex_mem_rd  = ex_q.mem_rd;
   assign ex_mem_wr  = ex_q.mem_wr;
   assign ex_branch  = ex_q.branch;
   assign ex_in1     = in1_q;
   assign ex_in2     = in2_q;
   assign illegal_o  = ill_q;
   assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage using directed vectors.
module tb_alu_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [2:0]  rs_addr, rt_addr;
   logic [9:0]  rs_data, rt_data;
   logic        stall_i, flush_i;
   logic        ex_valid;
   logic [2:0]  ex_ctl;
   logic [9:0]  ex_in1, ex_in2;
   logic [2:0]  ex_rd;
   logic        ex_wr_en, ex_mem_rd, ex_mem_wr, ex_branch;
   logic        illegal_o;
   logic [7:0]  hazard_cnt;

   typedef struct packed {
      logic       valid;
      logic [2:0] ctl;
      logic [9:0] in1;
      logic [9:0] in2;
      logic [2:0] rd;
      logic       wr;
      logic       mrd;
      logic       mwr;
      logic       br;
      logic       ill;
      logic [7:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   alu_decode_stage #(.SIZE(10), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .stall_i(stall_i), .flush_i(flush_i),
      .ex_valid(ex_valid), .ex_ctl(ex_ctl),
      .ex_in1(ex_in1), .ex_in2(ex_in2),
      .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_branch(ex_branch), .illegal_o(illegal_o),
      .hazard_cnt(hazard_cnt)
   );

   function automatic exp_t ex(
      logic v, logic [2:0] c, logic [9:0] i1, logic [9:0] i2,
      logic [2:0] rd, logic w, logic mr, logic mw, logic b,
      logic il, logic [7:0] cn);
      ex = '{valid: v, ctl: c, in1: i1, in2: i2, rd: rd,
             wr: w, mrd: mr, mwr: mw, br: b, ill: il, cnt: cn};
   endfunction

   function automatic exp_t bub(logic il, logic [7:0] cn);
      bub = ex(1'b0, 3'b111, 10'd0, 10'd0, 3'd0,
               1'b0, 1'b0, 1'b0, 1'b0, il, cn);
   endfunction

   function automatic logic [15:0] mk(
      logic [3:0] op, logic [2:0] rd, logic [2:0] rs, logic [2:0] rt);
      mk = {op, rd, rs, rt, 3'b000};
   endfunction

   // Monitor: each cycle's registered outputs against the queue head.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = '{valid: ex_valid, ctl: ex_ctl, in1: ex_in1,
                in2: ex_in2, rd: ex_rd, wr: ex_wr_en,
                mrd: ex_mem_rd, mwr: ex_mem_wr, br: ex_branch,
                ill: illegal_o, cnt: hazard_cnt};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s got v=%b ctl=%b in1=%h in2=%h rd=%0d w=%b mr=%b mw=%b br=%b ill=%b cnt=%0d want v=%b ctl=%b in1=%h in2=%h rd=%0d w=%b mr=%b mw=%b br=%b ill=%b cnt=%0d",
                     nm, a.valid, a.ctl, a.in1, a.in2, a.rd, a.wr,
                     a.mrd, a.mwr, a.br, a.ill, a.cnt,
                     e.valid, e.ctl, e.in1, e.in2, e.rd, e.wr,
                     e.mrd, e.mwr, e.br, e.ill, e.cnt);
         end
      end
   end

   task automatic step(
      input logic r, input logic v, input logic [15:0] ins,
      input logic [9:0] a, input logic [9:0] b,
      input logic st, input logic fl, input logic rdy,
      input exp_t e, input string nm);
      rst = r; instr_valid = v; instr = ins;
      rs_data = a; rt_data = b; stall_i = st; flush_i = fl;
      #1;
      checks++;
      if (instr_ready !== rdy) begin
         errors++;
         $display("FAIL ready_%s got=%b want=%b", nm, instr_ready, rdy);
      end
      checks++;
      if ({rs_addr, rt_addr} !== {ins[8:6], ins[5:3]}) begin
         errors++;
         $display("FAIL addr_%s got=%h want=%h",
                  nm, {rs_addr, rt_addr}, {ins[8:6], ins[5:3]});
      end
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      logic [15:0] i_or, i_asl, i_ld, i_sub;
      logic [7:0]  c;
      int          wait_cyc;
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      rs_data = '0; rt_data = '0; stall_i = 1'b0; flush_i = 1'b0;

      step(1, 0, 16'h0, 0, 0, 0, 0, 0, bub(0, 0), "reset0");
      step(1, 0, 16'h0, 0, 0, 0, 0, 0, bub(0, 0), "reset1");

      step(0, 1, mk(4'h1, 3, 1, 2), 10'd5, 10'd7, 0, 0, 1,
           ex(1, 3'b001, 10'd5, 10'd7, 3, 1, 0, 0, 0, 0, 0), "add");
      step(0, 1, {4'hA, 3'd1, 3'd2, 6'b111110}, 10'd4, 10'd9, 0, 0, 1,
           ex(1, 3'b001, 10'd4, 10'h3FE, 1, 1, 0, 0, 0, 0, 0), "addi");

      step(0, 1, mk(4'h7, 2, 5, 0), 10'h010, 10'h0, 0, 0, 1,
           ex(1, 3'b000, 10'h010, 10'd0, 2, 1, 1, 0, 0, 0, 0), "ld");
      step(0, 1, mk(4'h2, 4, 2, 1), 10'd9, 10'd3, 0, 0, 0,
           bub(0, 1), "hazard_bubble");
      step(0, 1, mk(4'h2, 4, 2, 1), 10'd9, 10'd3, 0, 0, 1,
           ex(1, 3'b011, 10'd9, 10'd3, 4, 1, 0, 0, 0, 0, 1), "sub");

      step(0, 1, mk(4'hC, 1, 2, 3), 10'h1FF, 10'h1FF, 0, 0, 1,
           bub(1, 1), "illegal");
      step(0, 0, 16'h0, 0, 0, 0, 0, 1, bub(0, 1), "illegal_end");

      step(0, 1, mk(4'h3, 5, 6, 7), 10'h0F0, 10'h3CC, 0, 0, 1,
           ex(1, 3'b010, 10'h0F0, 10'h3CC, 5, 1, 0, 0, 0, 0, 1), "and");
      i_or  = mk(4'h4, 6, 1, 3);
      i_asl = mk(4'h5, 1, 4, 2);
      step(0, 1, i_or, 10'h101, 10'h0AA, 0, 0, 1,
           ex(1, 3'b101, 10'h101, 10'h0AA, 6, 1, 0, 0, 0, 0, 1), "or");
      for (int k = 0; k < 3; k++)
         step(0, 1, i_asl, 10'h2AB, 10'h155, 1, 0, 0,
              ex(1, 3'b101, 10'h101, 10'h0AA, 6, 1, 0, 0, 0, 0, 1),
              "stall_hold");
      step(0, 1, i_asl, 10'h2AB, 10'h155, 1, 1, 1,
           bub(0, 1), "flush_in_stall");
      step(0, 1, i_asl, 10'h2AB, 10'h155, 0, 0, 1,
           ex(1, 3'b100, 10'h2AB, 10'd0, 1, 1, 0, 0, 0, 0, 1), "asla");
      step(0, 1, mk(4'h6, 2, 3, 5), 10'h300, 10'h0FF, 0, 0, 1,
           ex(1, 3'b110, 10'h300, 10'd0, 2, 1, 0, 0, 0, 0, 1), "asra");
      step(0, 1, mk(4'h8, 0, 1, 2), 10'h012, 10'h345, 0, 0, 1,
           ex(1, 3'b000, 10'h012, 10'h345, 0, 0, 0, 1, 0, 0, 1), "st");
      step(0, 1, mk(4'h9, 0, 3, 4), 10'h111, 10'h222, 0, 0, 1,
           ex(1, 3'b111, 10'd0, 10'd0, 0, 0, 0, 0, 1, 0, 1), "br");
      step(0, 1, mk(4'h0, 7, 7, 7), 10'h111, 10'h222, 0, 0, 1,
           bub(0, 1), "nop");

      i_ld  = mk(4'h7, 1, 0, 0);
      i_sub = mk(4'h2, 3, 1, 2);
      step(0, 1, i_ld, 10'h020, 10'h0, 0, 0, 1,
           ex(1, 3'b000, 10'h020, 10'd0, 1, 1, 1, 0, 0, 0, 1), "ld2");
      step(0, 1, i_sub, 10'h005, 10'h002, 1, 0, 0,
           ex(1, 3'b000, 10'h020, 10'd0, 1, 1, 1, 0, 0, 0, 1),
           "stall_over_hazard");
      step(0, 1, i_sub, 10'h005, 10'h002, 0, 0, 0,
           bub(0, 2), "hazard2");
      step(0, 1, i_sub, 10'h005, 10'h002, 0, 0, 1,
           ex(1, 3'b011, 10'h005, 10'h002, 3, 1, 0, 0, 0, 0, 2), "sub2");

      c = 8'd2;
      for (int k = 0; k < 300; k++) begin
         step(0, 1, i_ld, 10'h0, 10'h0, 0, 0, 1,
              ex(1, 3'b000, 10'd0, 10'd0, 1, 1, 1, 0, 0, 0, c), "pair_ld");
         if (c != 8'd255) c = c + 8'd1;
         step(0, 1, i_sub, 10'h0, 10'h0, 0, 0, 0, bub(0, c), "pair_haz");
      end

      step(0, 1, i_ld, 10'h0, 10'h0, 0, 0, 1,
           ex(1, 3'b000, 10'd0, 10'd0, 1, 1, 1, 0, 0, 0, 255), "sat_ld");
      step(1, 1, i_sub, 10'h0, 10'h0, 0, 0, 0, bub(0, 0), "rst_in_hazard");
      step(0, 1, i_or, 10'h101, 10'h0AA, 0, 0, 1,
           ex(1, 3'b101, 10'h101, 10'h0AA, 6, 1, 0, 0, 0, 0, 0), "or2");
      step(1, 1, i_asl, 10'h2AB, 10'h155, 1, 0, 0,
           bub(0, 0), "rst_in_stall");
      step(0, 0, 16'h0, 0, 0, 0, 0, 1, bub(0, 0), "idle");

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 5) begin
         @(posedge clk);
         wait_cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d want=0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
